accum_delta_decoder: RTL and testbench

- Receive end of the running-sum accumulator link.
- Takes the 16-bit running sum, delivered as two bytes (low byte first) on an 8-bit bus.
- Recovers the 8-bit increment that produced each new sum by differencing consecutive sums, and flags sums whose step cannot be an 8-bit increment.
- Sits on the host/test side of the accumulator output pins and feeds downstream checkers.

---
 rtl/accum_delta_decoder.sv | 89 ++++++++
 tb/tb_accum_delta_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/accum_delta_decoder.sv
// Receive side of the running-sum accumulator link: rebuilds 16-bit sums from
// a low-first byte stream and recovers the 8-bit increment between sums.
module accum_delta_decoder #(
    parameter int SUM_W    = 16,
    parameter int BYTE_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_sync,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                byte_valid,
    output logic [BYTE_W-1:0]   delta_out,
    output logic                delta_valid,
    output logic                range_err,
    output logic                primed,
    output logic [ERRCNT_W-1:0] err_count
);

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_t;

    phase_t             phase;
    logic [BYTE_W-1:0]  lo_hold;
    logic [SUM_W-1:0]   prev_sum;
    logic [SUM_W-1:0]   word_p0;
    logic [SUM_W-1:0]   diff_p0;
    logic               overflow_p0;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + ERRCNT_W'(1);
    endfunction

    // Stage p0: assemble the word and difference it against the reference sum;
    // unsigned modular subtraction absorbs counter wrap.
    assign word_p0     = {byte_in, lo_hold};
    assign diff_p0     = word_p0 - prev_sum;
    assign overflow_p0 = |diff_p0[SUM_W-1:BYTE_W];

    // Stage p1: registered outputs, one cycle after the high byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= PH_LOW;
            lo_hold     <= '0;
            prev_sum    <= '0;
            primed      <= 1'b0;
            delta_out   <= '0;
            delta_valid <= 1'b0;
            range_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            delta_valid <= 1'b0;
            if (frame_sync) begin
                primed <= 1'b0;
                if (byte_valid) begin
                    lo_hold <= byte_in;
                    phase   <= PH_HIGH;
                end else begin
                    phase   <= PH_LOW;
                end
            end else if (byte_valid) begin
                case (phase)
                    PH_LOW: begin
                        lo_hold <= byte_in;
                        phase   <= PH_HIGH;
                    end
                    PH_HIGH: begin
                        phase    <= PH_LOW;
                        prev_sum <= word_p0;
                        if (!primed) begin
                            primed <= 1'b1;
                        end else begin
                            delta_out   <= diff_p0[BYTE_W-1:0];
                            range_err   <= overflow_p0;
                            delta_valid <= 1'b1;
                            if (overflow_p0) begin
                                err_count <= sat_inc(err_count);
                            end
                        end
                    end
                    default: phase <= PH_LOW;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accum_delta_decoder.sv
// Directed bench for accum_delta_decoder: per-cycle vector table plus
// hand-written saturation, streaming and reset-mid-word sequences.
module tb_accum_delta_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_sync;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] delta_out;
    logic       delta_valid;
    logic       range_err;
    logic       primed;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    accum_delta_decoder #(.SUM_W(16), .BYTE_W(8), .ERRCNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .delta_out  (delta_out),
        .delta_valid(delta_valid),
        .range_err  (range_err),
        .primed     (primed),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       fs;
        logic       bv;
        logic [7:0] b;
        logic       dv;
        logic [7:0] dout;
        logic       re;
        logic       pr;
        logic [7:0] ec;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic fs, input logic bv, input logic [7:0] b,
                                input logic dv, input logic [7:0] dout, input logic re,
                                input logic pr, input logic [7:0] ec);
        vec_t v;
        v.fs = fs; v.bv = bv; v.b = b; v.dv = dv; v.dout = dout; v.re = re; v.pr = pr; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, input logic bv, input logic [7:0] b);
        frame_sync = fs;
        byte_valid = bv;
        byte_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic dv, input logic [7:0] dout,
                           input logic re, input logic pr, input logic [7:0] ec);
        chk({tag, ".delta_valid"}, 32'(delta_valid), 32'(dv));
        chk({tag, ".delta_out"},   32'(delta_out),   32'(dout));
        chk({tag, ".range_err"},   32'(range_err),   32'(re));
        chk({tag, ".primed"},      32'(primed),      32'(pr));
        chk({tag, ".err_count"},   32'(err_count),   32'(ec));
    endtask

    initial begin
        logic [15:0] sum;
        logic [7:0]  exp_ec;

        // prime then step (0x0010 -> 0x0015)
        vecs[0]  = mk(0, 1, 8'h10, 0, 8'h00, 0, 0, 8'd0);
        vecs[1]  = mk(0, 1, 8'h00, 0, 8'h00, 0, 1, 8'd0);
        vecs[2]  = mk(0, 1, 8'h15, 0, 8'h00, 0, 1, 8'd0);
        vecs[3]  = mk(0, 1, 8'h00, 1, 8'h05, 0, 1, 8'd0);
        vecs[4]  = mk(0, 0, 8'h00, 0, 8'h05, 0, 1, 8'd0);
        // wrap: prime 0xFFFE via frame_sync low byte, then 0x0003
        vecs[5]  = mk(1, 1, 8'hFE, 0, 8'h05, 0, 0, 8'd0);
        vecs[6]  = mk(0, 1, 8'hFF, 0, 8'h05, 0, 1, 8'd0);
        vecs[7]  = mk(0, 1, 8'h03, 0, 8'h05, 0, 1, 8'd0);
        vecs[8]  = mk(0, 1, 8'h00, 1, 8'h05, 0, 1, 8'd0);
        // range error: prime 0x0000, then 0x0200
        vecs[9]  = mk(1, 1, 8'h00, 0, 8'h05, 0, 0, 8'd0);
        vecs[10] = mk(0, 1, 8'h00, 0, 8'h05, 0, 1, 8'd0);
        vecs[11] = mk(0, 1, 8'h00, 0, 8'h05, 0, 1, 8'd0);
        vecs[12] = mk(0, 1, 8'h02, 1, 8'h00, 1, 1, 8'd1);
        vecs[13] = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'd1);
        // sync mid-word: 0xAA discarded, 0x0020 primes, 0x0021 gives 1
        vecs[14] = mk(1, 0, 8'h00, 0, 8'h00, 1, 0, 8'd1);
        vecs[15] = mk(0, 1, 8'hAA, 0, 8'h00, 1, 0, 8'd1);
        vecs[16] = mk(1, 1, 8'h20, 0, 8'h00, 1, 0, 8'd1);
        vecs[17] = mk(0, 1, 8'h00, 0, 8'h00, 1, 1, 8'd1);
        vecs[18] = mk(0, 1, 8'h21, 0, 8'h00, 1, 1, 8'd1);
        vecs[19] = mk(0, 1, 8'h00, 1, 8'h01, 0, 1, 8'd1);
        // zero difference is legal
        vecs[20] = mk(0, 1, 8'h21, 0, 8'h01, 0, 1, 8'd1);
        vecs[21] = mk(0, 1, 8'h00, 1, 8'h00, 0, 1, 8'd1);

        rst = 1'b1;
        frame_sync = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);
        chk_all("reset", 0, 8'h00, 0, 0, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fs, vecs[i].bv, vecs[i].b);
            chk_all($sformatf("vec%0d", i), vecs[i].dv, vecs[i].dout, vecs[i].re,
                    vecs[i].pr, vecs[i].ec);
        end

        // saturation: prev_sum is 0x0021, keep stepping by 0x0200
        sum = 16'h0021;
        exp_ec = 8'd1;
        for (int k = 0; k < 300; k++) begin
            sum = sum + 16'h0200;
            drive(0, 1, sum[7:0]);
            drive(0, 1, sum[15:8]);
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            chk($sformatf("sat%0d.err_count", k), 32'(err_count), 32'(exp_ec));
            chk($sformatf("sat%0d.range_err", k), 32'(range_err), 32'd1);
        end
        chk("sat.final", 32'(err_count), 32'hFF);

        // streaming: resync, prime 0x0000, then running sums of 1..10 back to back
        drive(1, 0, 8'h00);
        chk("stream.unprimed", 32'(primed), 32'd0);
        drive(0, 1, 8'h00);
        drive(0, 1, 8'h00);
        chk("stream.primed", 32'(primed), 32'd1);
        sum = 16'h0000;
        for (int k = 1; k <= 10; k++) begin
            sum = sum + 16'(k);
            drive(0, 1, sum[7:0]);
            chk($sformatf("stream%0d.gap", k), 32'(delta_valid), 32'd0);
            drive(0, 1, sum[15:8]);
            chk_all($sformatf("stream%0d", k), 1, 8'(k), 0, 1, 8'hFF);
        end

        // reset mid-word: low byte 0x55 then rst; next word only primes
        drive(0, 1, 8'h55);
        rst = 1'b1;
        drive(1, 1, 8'h99);
        rst = 1'b0;
        chk_all("midrst", 0, 8'h00, 0, 0, 8'd0);
        drive(0, 1, 8'h07);
        chk_all("midrst.lo", 0, 8'h00, 0, 0, 8'd0);
        drive(0, 1, 8'h00);
        chk_all("midrst.hi", 0, 8'h00, 0, 1, 8'd0);
        // next word 0x0009 proves reference was 0x0007
        drive(0, 1, 8'h09);
        drive(0, 1, 8'h00);
        chk_all("midrst.step", 1, 8'h02, 0, 1, 8'd0);
        drive(0, 0, 8'h00);
        chk("midrst.pulse_end", 32'(delta_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
